// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, bit-timing helper and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Integer division truncates; callers must ensure the result is >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, one-clock tick at the
// terminal count, and holds at zero while disabled so every bit starts a full period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  // NOTE: default first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// A byte is accepted on tx_valid && tx_ready; tx comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          idx_d   = '0;
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = STOP_BIT;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the line high immediately, aborting any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit: frame shape, bit timing,
// back-to-back handshakes, input masking while busy and mid-frame reset.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .DATA_BITS(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after an edge while idle; the handshake happens at the next edge.
  task automatic send(input logic [7:0] d, input bit hold);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Entered 1ns after the handshake edge; leaves 1ns after the IDLE re-entry edge.
  // Optionally pokes new data/valid into the middle of the frame.
  task automatic expect_frame(input logic [7:0] d, input string tag, input bit poke);
    logic [9:0] fb;
    logic [7:0] rx;
    int ok, busy_n, rdy_n;
    fb     = {1'b1, d, 1'b0};
    rx     = 8'h00;
    busy_n = 0;
    rdy_n  = 0;
    for (int k = 0; k < 10; k++) begin
      ok = 0;
      for (int c = 0; c < 10; c++) begin
        if (tx === fb[k]) ok++;
        if (busy === 1'b1) busy_n++;
        if (tx_ready === 1'b1) rdy_n++;
        if (c == 5 && k >= 1 && k <= 8) rx[k-1] = tx;
        if (poke && k == 3 && c == 2) begin
          tx_data  = 8'hFF;
          tx_valid = 1'b1;
        end
        if (poke && k == 3 && c == 4) tx_valid = 1'b0;
        step(1);
      end
      check($sformatf("%s_bit%0d_clks", tag, k), ok, 10);
    end
    check($sformatf("%s_rx", tag), {24'd0, rx}, {24'd0, d});
    check($sformatf("%s_busy_clks", tag), busy_n, 100);
    check($sformatf("%s_ready_low", tag), rdy_n, 0);
    check($sformatf("%s_end_ready", tag), {31'd0, tx_ready}, 32'd1);
    check($sformatf("%s_end_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_end_tx", tag), {31'd0, tx}, 32'd1);
  endtask

  // Watches the idle line for n clocks; any low bit or busy cycle is counted.
  task automatic expect_idle(input int n, input string tag);
    int low_n, busy_n;
    low_n  = 0;
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) low_n++;
      if (busy !== 1'b0) busy_n++;
      step(1);
    end
    check($sformatf("%s_tx_low", tag), low_n, 0);
    check($sformatf("%s_busy", tag), busy_n, 0);
  endtask

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    #12;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step(1);
    rst = 1'b0;
    expect_idle(5, "post_rst");

    // Single byte, one-cycle valid.
    send(8'hA5, 1'b0);
    expect_frame(8'hA5, "a5", 1'b0);
    step(3);

    // Edge values.
    send(8'h00, 1'b0);
    expect_frame(8'h00, "x00", 1'b0);
    step(2);
    send(8'hFF, 1'b0);
    expect_frame(8'hFF, "xff", 1'b0);
    step(2);

    // Back-to-back with tx_valid held; data changes while busy.
    send(8'h55, 1'b1);
    tx_data = 8'h3C;
    expect_frame(8'h55, "b2b_1", 1'b0);
    step(1);
    check("b2b_start_low", {31'd0, tx}, 32'd0);
    check("b2b_ready_pulse", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    expect_frame(8'h3C, "b2b_2", 1'b0);
    step(2);

    // Inputs ignored while busy.
    send(8'h12, 1'b0);
    expect_frame(8'h12, "ign", 1'b1);
    expect_idle(20, "ign_no_second");

    // Reset during data bit 3 of 0xC3.
    send(8'hC3, 1'b0);
    step(43);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst = 1'b0;
    expect_idle(30, "after_rst");
    send(8'h81, 1'b0);
    expect_frame(8'h81, "x81", 1'b0);
    step(2);

    // Bit-period timing on 0x5A.
    send(8'h5A, 1'b0);
    expect_frame(8'h5A, "t5a", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
